// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FP32 multiplier front end.
// Operands are unpacked once into {sign, effective exponent, mantissa with hidden bit}.
package fpu_mul_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int PROD_W   = 2 * MANT_W;
  localparam int LOPD_W   = 8;
  localparam int BIAS     = 127;
  localparam int EXP_MAX  = 254;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } operand_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  data_exp;
    logic              exp_oor;
    logic [PROD_W-1:0] mant_prod;
    logic              ov_flag;
    logic              un_flag;
    logic [LOPD_W-1:0] one_pos;
    logic              zero_flag;
  } result_t;

  // Subnormals take exponent 1 and a clear hidden bit.
  function automatic operand_t unpack(input logic [FP_W-1:0] v);
    operand_t r;
    r.sign = v[FP_W-1];
    r.exp  = (v[FP_W-2:FRAC_W] == '0) ? EXP_W'(1) : v[FP_W-2:FRAC_W];
    r.mant = {(v[FP_W-2:FRAC_W] != '0), v[FRAC_W-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/fpu_mul_prenorm_pipe_if.sv
// Operand/result handshake bundle for the multiplier front end.
// slave is the pipe side, master is the producer/consumer side.
interface fpu_mul_prenorm_pipe_if #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_MANT = 24,
  parameter int SIZE_LOPD = 8
);
  logic                   i_valid;
  logic                   o_ready;
  logic [31:0]            i_data_a;
  logic [31:0]            i_data_b;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_sign;
  logic [SIZE_DATA-1:0]   o_data_exp;
  logic                   o_exp_oor;
  logic [2*SIZE_MANT-1:0] o_mant_prod;
  logic                   o_ov_flag;
  logic                   o_un_flag;
  logic [SIZE_LOPD-1:0]   o_one_pos;
  logic                   o_zero_flag;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_sign, o_data_exp, o_exp_oor, o_mant_prod,
           o_ov_flag, o_un_flag, o_one_pos, o_zero_flag
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_sign, o_data_exp, o_exp_oor, o_mant_prod,
           o_ov_flag, o_un_flag, o_one_pos, o_zero_flag
  );
endinterface

// File: rtl/fpu_mul_lopd48.sv
// Leading-one detector on product bits 46:0; one_pos is the distance of
// the highest set bit below bit 46 (0 when bit 46 is set or all are clear).
module fpu_mul_lopd48 #(
  parameter int SIZE_LOPD = 8
) (
  input  logic [46:0]          prod_low,
  output logic [SIZE_LOPD-1:0] one_pos,
  output logic                 all_zero
);

  always_comb begin
    one_pos = '0;
    for (int i = 0; i < 47; i++) begin
      if (prod_low[i]) one_pos = SIZE_LOPD'(46 - i);
    end
  end

  assign all_zero = ~|prod_low;

endmodule

// File: rtl/fpu_mul_prenorm_pipe.sv
// Two-stage FP32 multiplier front end: stage 1 unpacks and sums exponents,
// stage 2 holds the mantissa product and its normalisation flags.
module fpu_mul_prenorm_pipe
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_MANT = 24,
  parameter int SIZE_LOPD = 8,
  parameter int BIAS      = 127
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  fpu_mul_prenorm_pipe_if.slave  bus
);

  localparam int SUM_W = SIZE_DATA + 2;

  operand_t                   op_a;
  operand_t                   op_b;
  logic signed [SUM_W-1:0]    exp_sum;

  logic                       s1_valid;
  logic                       s1_sign;
  logic signed [SUM_W-1:0]    s1_exp_sum;
  logic [SIZE_MANT-1:0]       s1_mant_a;
  logic [SIZE_MANT-1:0]       s1_mant_b;

  logic                       s2_valid;
  result_t                    s2_res;
  result_t                    s2_next;

  logic                       s1_load;
  logic                       s2_load;
  logic [2*SIZE_MANT-1:0]     prod;
  logic [SIZE_LOPD-1:0]       lopd_pos;
  logic                       lopd_zero;

  assign op_a    = unpack(bus.i_data_a);
  assign op_b    = unpack(bus.i_data_b);
  assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - SUM_W'(BIAS);

  assign s2_load     = ~s2_valid | bus.i_ready;
  assign s1_load     = ~s1_valid | s2_load;
  assign bus.o_ready = s1_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp_sum <= '0;
      s1_mant_a  <= '0;
      s1_mant_b  <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign    <= op_a.sign ^ op_b.sign;
        s1_exp_sum <= exp_sum;
        s1_mant_a  <= op_a.mant;
        s1_mant_b  <= op_b.mant;
      end
    end
  end

  assign prod = s1_mant_a * s1_mant_b;

  fpu_mul_lopd48 #(.SIZE_LOPD(SIZE_LOPD)) u_lopd (
    .prod_low (prod[46:0]),
    .one_pos  (lopd_pos),
    .all_zero (lopd_zero)
  );

  // Flags are mutually exclusive: zero, then bit 47, then bit 46, then one_pos.
  always_comb begin
    s2_next           = '0;
    s2_next.sign      = s1_sign;
    s2_next.data_exp  = s1_exp_sum[SIZE_DATA-1:0];
    s2_next.exp_oor   = (s1_exp_sum < SUM_W'(1)) || (s1_exp_sum > SUM_W'(EXP_MAX));
    s2_next.mant_prod = prod;
    s2_next.ov_flag   = prod[47];
    s2_next.un_flag   = ~prod[47] & prod[46];
    s2_next.zero_flag = ~prod[47] & lopd_zero;
    s2_next.one_pos   = (prod[47] | prod[46]) ? '0 : lopd_pos;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_res <= s2_next;
    end
  end

  assign bus.o_valid     = s2_valid;
  assign bus.o_sign      = s2_res.sign;
  assign bus.o_data_exp  = s2_res.data_exp;
  assign bus.o_exp_oor   = s2_res.exp_oor;
  assign bus.o_mant_prod = s2_res.mant_prod;
  assign bus.o_ov_flag   = s2_res.ov_flag;
  assign bus.o_un_flag   = s2_res.un_flag;
  assign bus.o_one_pos   = s2_res.one_pos;
  assign bus.o_zero_flag = s2_res.zero_flag;

endmodule

// File: tb/tb_fpu_mul_prenorm_pipe.sv
// Bench for the FP32 multiplier front end: arithmetic reference model with an
// in-order expectation queue, directed vectors, stall/reset scenarios, random traffic.
module tb_fpu_mul_prenorm_pipe;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic        oor;
    logic [47:0] prod;
    logic        ov;
    logic        un;
    logic [7:0]  pos;
    logic        zero;
  } exp_t;

  logic i_clk;
  logic i_rst_n;

  fpu_mul_prenorm_pipe_if #(.SIZE_DATA(8), .SIZE_MANT(24), .SIZE_LOPD(8)) bus ();

  fpu_mul_prenorm_pipe dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   pops = 0;
  bit   saw_ready_low = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, sum, h;
    longint unsigned ma, mb, p;
    ea  = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb  = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma  = {40'd0, (a[30:23] != 8'd0), a[22:0]};
    mb  = {40'd0, (b[30:23] != 8'd0), b[22:0]};
    p   = ma * mb;
    sum = ea + eb - 127;
    r = '0;
    r.sign = a[31] ^ b[31];
    r.exp  = 8'(sum & 255);
    r.oor  = (sum < 1) || (sum > 254);
    r.prod = p[47:0];
    if (p == 0) r.zero = 1'b1;
    else if (p >= (64'd1 << 47)) r.ov = 1'b1;
    else if (p >= (64'd1 << 46)) r.un = 1'b1;
    else begin
      h = 45;
      while (((p >> h) & 64'd1) == 64'd0) h--;
      r.pos = 8'(46 - h);
    end
    return r;
  endfunction

  function automatic exp_t dut_out();
    exp_t r;
    r.sign = bus.o_sign;
    r.exp  = bus.o_data_exp;
    r.oor  = bus.o_exp_oor;
    r.prod = bus.o_mant_prod;
    r.ov   = bus.o_ov_flag;
    r.un   = bus.o_un_flag;
    r.pos  = bus.o_one_pos;
    r.zero = bus.o_zero_flag;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: the cycle's transfers are decided by values sampled mid-cycle.
  initial begin : monitor
    exp_t  e, got;
    logic [$bits(exp_t):0] snap, cur;
    bit    prev_stall;
    prev_stall = 0;
    snap = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        q.delete();
        prev_stall = 0;
      end else begin
        if (!bus.o_ready) saw_ready_low = 1;
        chk("o_ready", bus.o_ready, (q.size() < 2) || bus.i_ready);
        cur = {bus.o_valid, dut_out()};
        if (prev_stall) chk("stall_hold", cur, snap);
        if (bus.o_valid && !bus.i_ready) begin
          snap = cur;
          prev_stall = 1;
        end else prev_stall = 0;
        if (bus.o_valid && bus.i_ready) begin
          if (q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e   = q.pop_front();
            got = dut_out();
            chk("result", got, e);
            pops++;
          end
        end
        if (bus.i_valid && bus.o_ready) q.push_back(model(bus.i_data_a, bus.i_data_b));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    bus.i_valid  = 1'b1;
    bus.i_data_a = a;
    bus.i_data_b = b;
    while (!done) begin
      @(negedge i_clk);
      done = bus.o_ready;
      @(posedge i_clk);
      #1;
      n++;
      if (!done && n > 60) begin
        chk("send_timeout", 1, 0);
        done = 1;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0) && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [7:0] ex, input logic oor,
                          input logic [47:0] pr, input logic ov, input logic un,
                          input logic [7:0] pos, input logic z);
    send(a, b);
    chk({nm, "_lat1"}, bus.o_valid, 0);
    @(posedge i_clk);
    #1;
    chk({nm, "_lat2"}, bus.o_valid, 1);
    chk({nm, "_sign"}, bus.o_sign, sg);
    chk({nm, "_exp"}, bus.o_data_exp, ex);
    chk({nm, "_oor"}, bus.o_exp_oor, oor);
    chk({nm, "_prod"}, bus.o_mant_prod, pr);
    chk({nm, "_flags"}, {bus.o_ov_flag, bus.o_un_flag, bus.o_zero_flag}, {ov, un, z});
    chk({nm, "_pos"}, bus.o_one_pos, pos);
    drain();
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: v[30:23] = 8'd0;
      2: v[30:0] = 31'd0;
      3: begin v[30:23] = 8'd0; v[22:0] = v[22:0] >> $urandom_range(0, 22); end
      4: v[30:23] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(250, 255));
      default: v[30:23] = 8'($urandom_range(120, 134));
    endcase
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t m;
    bit   rnd_on;
    bus.i_valid  = 1'b0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_ready  = 1'b1;
    i_rst_n      = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 1);
    chk("rst_outputs", dut_out(), '0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    m = model(32'h3FC00000, 32'h3FC00000);
    chk("model_pin_prod", m.prod, 48'h900000000000);
    m = model(32'h00400000, 32'h3F800000);
    chk("model_pin_pos", m.pos, 8'd1);

    directed("one_x_one", 32'h3F800000, 32'h3F800000, 0, 8'd127, 0, 48'h400000000000, 0, 1, 8'd0, 0);
    directed("1p5_sq",    32'h3FC00000, 32'h3FC00000, 0, 8'd127, 0, 48'h900000000000, 1, 0, 8'd0, 0);
    directed("subnorm",   32'h00400000, 32'h3F800000, 0, 8'd1,   0, 48'h200000000000, 0, 0, 8'd1, 0);
    directed("zero",      32'h00000000, 32'hC0000000, 1, 8'd2,   0, 48'h000000000000, 0, 0, 8'd0, 1);
    directed("exp_oor",   32'h7F000000, 32'h7F000000, 0, 8'd125, 1, 48'h400000000000, 0, 1, 8'd0, 0);

    // Back-to-back stream with a 3-cycle downstream stall in the middle.
    pops = 0;
    saw_ready_low = 0;
    fork
      begin
        send(32'h3F800000, 32'h40000000);
        send(32'h3FC00000, 32'hBF800000);
        send(32'h00000001, 32'h3F800000);
        send(32'h40400000, 32'h40400000);
      end
      begin
        @(posedge i_clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", pops, 4);
    chk("stream_ready_drop", saw_ready_low, 1);

    // Reset with two results in flight.
    bus.i_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000);
    send(32'h40000000, 32'h40000000);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", bus.o_valid, 0);
    chk("midrst_prod", bus.o_mant_prod, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("postrst_queue", q.size(), 0);
    directed("post_rst", 32'h40000000, 32'h40400000, 0, 8'd129, 0, 48'h600000000000, 0, 1, 8'd0, 0);

    // Random traffic with random downstream back-pressure.
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) send(rand_op(), rand_op());
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge i_clk);
          #1;
          bus.i_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    bus.i_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
